// File: rtl/micro_x86_seq_ctrl_if.sv
// Sequencer <-> datapath handshake and strobe bundle.
// master: the sequencer (drives fetch/memory requests and datapath strobes).
// slave : the datapath/memory side (drives instr_valid, opcode, mode, zero_flag, mem_ack).
interface micro_x86_seq_ctrl_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned MODE_W = 4;

  logic              instr_valid;
  logic              instr_req;
  logic              ir_load;
  logic [OP_W-1:0]   opcode;
  logic [MODE_W-1:0] mode;
  logic              zero_flag;
  logic              mem_ack;
  logic              b_sel_imm;
  logic              rf_we;
  logic              mem_req;
  logic              mem_we;
  logic              pc_en;
  logic              pc_sel_br;

  modport master (
    input  instr_valid, opcode, mode, zero_flag, mem_ack,
    output instr_req, ir_load, b_sel_imm, rf_we, mem_req, mem_we, pc_en, pc_sel_br
  );

  modport slave (
    output instr_valid, opcode, mode, zero_flag, mem_ack,
    input  instr_req, ir_load, b_sel_imm, rf_we, mem_req, mem_we, pc_en, pc_sel_br
  );
endinterface

// File: rtl/micro_x86_seq_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with HALTED and TRAP terminals.
// Ports: clk, reset (async active-low); bus (master modport: fetch + data-memory
// handshakes, datapath strobes); halted/trap/trap_code sticky status; retired count.
// instr_req, rf_we, mem_req, mem_we and status are registered from the next state;
// ir_load, pc_en, pc_sel_br, b_sel_imm react to same-cycle inputs and are combinational.
module micro_x86_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  micro_x86_seq_ctrl_if.master    bus,
  output logic                    halted,
  output logic                    trap,
  output logic [1:0]              trap_code,
  output logic [CNT_W-1:0]        retired
);
  localparam int unsigned TO_W = 8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED,
    S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]        trap_code_q, trap_code_d;
  logic              instr_req_q, rf_we_q, mem_req_q, mem_we_q, halted_q, trap_q;
  logic [CNT_W-1:0]  retired_q;
  logic              ir_load_c, pc_en_c, pc_sel_br_c, b_sel_imm_c;
  logic              op_alu, op_load, op_store, op_jz, op_jmp, op_halt, op_ill;
  logic              mode_unused;

  // Opcode classes from the decoder
  assign op_alu   = ~bus.opcode[3];
  assign op_load  = (bus.opcode == 4'h8);
  assign op_store = (bus.opcode == 4'h9);
  assign op_jz    = (bus.opcode == 4'hA);
  assign op_jmp   = (bus.opcode == 4'hB);
  assign op_halt  = (bus.opcode == 4'hF);
  assign op_ill   = (bus.opcode == 4'hC) || (bus.opcode == 4'hD) || (bus.opcode == 4'hE);
  assign mode_unused = ^bus.mode[3:1];

  // Next-state and same-cycle strobes
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = '0;
    trap_code_d  = trap_code_q;
    ir_load_c    = 1'b0;
    pc_en_c      = 1'b0;
    pc_sel_br_c  = 1'b0;
    b_sel_imm_c  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (instr_req_q && bus.instr_valid) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_ill) begin
          state_d     = S_TRAP;
          trap_code_d = 2'b01;
        end else if (op_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Memory ops always add the immediate to form the address
        b_sel_imm_c = op_load || op_store || (op_alu && bus.mode[0]);
        if (op_load || op_store) begin
          state_d = S_MEM;
        end else if (op_jmp || op_jz) begin
          pc_en_c     = 1'b1;
          pc_sel_br_c = op_jmp || bus.zero_flag;
          state_d     = S_FETCH;
        end else if (op_alu) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (op_store) begin
            pc_en_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          // This is the MEM_TIMEOUT-th cycle without an ack
          state_d     = S_TRAP;
          trap_code_d = 2'b10;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        pc_en_c = 1'b1;
        state_d = S_FETCH;
      end
      S_HALTED, S_TRAP: state_d = state_q;
      default:          state_d = S_FETCH;
    endcase
  end

  // State, timeout counter, registered outputs and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      to_cnt_q    <= '0;
      trap_code_q <= 2'b00;
      instr_req_q <= 1'b0;
      rf_we_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      trap_code_q <= trap_code_d;
      instr_req_q <= (state_d == S_FETCH);
      rf_we_q     <= (state_d == S_WB);
      mem_req_q   <= (state_d == S_MEM);
      mem_we_q    <= (state_d == S_MEM) && op_store;
      halted_q    <= (state_d == S_HALTED);
      trap_q      <= (state_d == S_TRAP);
      if (pc_en_c) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.instr_req = instr_req_q;
  assign bus.ir_load   = ir_load_c;
  assign bus.b_sel_imm = b_sel_imm_c;
  assign bus.rf_we     = rf_we_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.pc_en     = pc_en_c;
  assign bus.pc_sel_br = pc_sel_br_c;
  assign halted        = halted_q;
  assign trap          = trap_q;
  assign trap_code     = trap_code_q;
  assign retired       = retired_q;
endmodule

// File: tb/tb_micro_x86_seq_ctrl.sv
// Scoreboard bench for micro_x86_seq_ctrl: the driver pushes the expected
// per-instruction outcome from an opcode-class model, the monitor pops on
// pc_en / trap / halted and compares.
module tb_micro_x86_seq_ctrl;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int K_RET  = 0;
  localparam int K_TRAP = 1;
  localparam int K_HALT = 2;

  typedef struct {
    int             kind;
    int             lat;
    bit             sel_br;
    bit             rf_we;
    int             memc;
    int             mwe;
    bit             bsel;
    logic [3:0]     st;
    logic [CNT_W-1:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic halted, trap;
  logic [1:0] trap_code;
  logic [CNT_W-1:0] retired;

  micro_x86_seq_ctrl_if bus();

  micro_x86_seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .halted    (halted),
    .trap      (trap),
    .trap_code (trap_code),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0] model_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected outcome of one instruction from its class, wait and flags
  function automatic exp_t model(input logic [3:0] op, input logic [3:0] md,
                                 input logic z, input int wt);
    exp_t e;
    e = '{default: 0};
    e.kind = K_RET;
    if (op <= 4'h7) begin
      e.lat = 3; e.rf_we = 1'b1; e.bsel = md[0];
    end else if (op == 4'h8 || op == 4'h9) begin
      e.bsel = 1'b1;
      if (wt >= int'(MEM_TIMEOUT)) begin
        e.kind = K_TRAP; e.lat = 3 + int'(MEM_TIMEOUT); e.memc = int'(MEM_TIMEOUT);
        e.st = 4'b0110;
      end else begin
        e.memc = wt + 1;
        e.lat = (op == 4'h8) ? 4 + wt : 3 + wt;
        e.rf_we = (op == 4'h8);
      end
      e.mwe = (op == 4'h9) ? e.memc : 0;
    end else if (op == 4'hA) begin
      e.lat = 2; e.sel_br = z;
    end else if (op == 4'hB) begin
      e.lat = 2; e.sel_br = 1'b1;
    end else if (op == 4'hF) begin
      e.kind = K_HALT; e.lat = 2; e.st = 4'b1000;
    end else begin
      e.kind = K_TRAP; e.lat = 2; e.st = 4'b0101;
    end
    return e;
  endfunction

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.instr_req, bus.ir_load, bus.b_sel_imm, bus.rf_we, bus.mem_req,
                     bus.mem_we, bus.pc_en, bus.pc_sel_br, halted, trap, trap_code, retired}), 32'd0);
  endtask

  // Present an instruction and return one cycle after it is accepted
  task automatic issue(input logic [3:0] op, input logic [3:0] md, input logic z);
    int g;
    bus.opcode = op; bus.mode = md; bus.zero_flag = z; bus.instr_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!bus.instr_req && g < 50) begin
      g++;
      @(negedge clk);
    end
    if (g >= 50) fail_now("accept_timeout");
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.mem_ack = 1'($urandom_range(0, 1));
  endtask

  // Memory responder: ack on MEM cycle wt+1, random ack noise outside MEM
  task automatic run_done(input int wt);
    int k, g;
    k = 0; g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        k++;
        bus.mem_ack = (k == wt + 1);
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      g++;
    end
    if (g >= 200) fail_now("completion_timeout");
    bus.mem_ack = 1'b0;
  endtask

  task automatic run(input logic [3:0] op, input logic [3:0] md, input logic z, input int wt);
    exp_t e;
    e = model(op, md, z, wt);
    if (e.kind == K_RET) model_ret = model_ret + CNT_W'(1);
    e.ret = model_ret;
    exp_q.push_back(e);
    issue(op, md, z);
    run_done(wt);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.instr_valid = 1'($urandom_range(0, 1));
    end
    bus.mem_ack = 1'b0;
    bus.instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    model_ret = '0;
    exp_q.delete();
    #1;
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor: track each accepted instruction and compare on its completion event
  initial begin : monitor
    exp_t e;
    bit active, pend, pt, ph, bsel;
    int t, memc, mwe;
    logic [CNT_W-1:0] pend_val;
    active = 0; pend = 0; pt = 0; ph = 0; bsel = 0; t = 0; memc = 0; mwe = 0; pend_val = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 0; pend = 0; pt = 0; ph = 0;
      end else begin
        if (pend) begin
          check("retired_count", 32'(retired), 32'(pend_val));
          pend = 0;
        end
        check("rf_we_mem_we_excl", 32'(bus.rf_we & bus.mem_we), 32'd0);
        if (bus.rf_we) check("rf_we_with_pc_en", 32'(bus.pc_en), 32'd1);
        if (halted || trap)
          check("terminal_quiet", 32'({bus.instr_req, bus.mem_req, bus.rf_we, bus.pc_en}), 32'd0);
        if (active) begin
          t++;
          if (t == 2) bsel = bus.b_sel_imm;
          if (bus.mem_req) memc++;
          if (bus.mem_we) mwe++;
          if (bus.pc_en || (trap && !pt) || (halted && !ph)) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_completion");
            end else begin
              e = exp_q.pop_front();
              check("event_kind", bus.pc_en ? K_RET : (trap ? K_TRAP : K_HALT), e.kind);
              check("latency", t, e.lat);
              check("mem_req_cycles", memc, e.memc);
              check("mem_we_cycles", mwe, e.mwe);
              if (e.kind == K_RET) begin
                check("pc_sel_br", 32'(bus.pc_sel_br), 32'(e.sel_br));
                check("rf_we_at_retire", 32'(bus.rf_we), 32'(e.rf_we));
                check("b_sel_imm_exec", 32'(bsel), 32'(e.bsel));
                pend = 1; pend_val = e.ret;
              end else begin
                check("status", 32'({halted, trap, trap_code}), 32'(e.st));
                check("retired_hold", 32'(retired), 32'(e.ret));
              end
            end
            active = 0;
          end
        end else if (bus.pc_en) begin
          fail_now("pc_en_without_instruction");
        end
        if (!active && bus.instr_req && bus.instr_valid) begin
          active = 1; t = 0; memc = 0; mwe = 0; bsel = 0;
        end
        pt = trap; ph = halted;
      end
    end
  end

  // Driver
  initial begin : driver
    int k, g;
    reset = 1'b0;
    bus.instr_valid = 1'b0; bus.opcode = 4'h0; bus.mode = 4'h0;
    bus.zero_flag = 1'b0; bus.mem_ack = 1'b0;
    model_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("initial_reset_outputs");
    reset = 1'b1;

    run(4'h3, 4'h1, 1'b0, 0);
    run(4'h8, 4'h0, 1'b0, 2);
    run(4'hA, 4'h0, 1'b1, 0);
    run(4'hA, 4'h0, 1'b0, 0);
    run(4'hB, 4'h3, 1'b0, 0);
    run(4'h9, 4'h0, 1'b1, 1);
    run(4'h5, 4'h0, 1'b1, 0);
    for (int i = 0; i < 80; i++) begin
      int unsigned c;
      c = $urandom_range(0, 11);
      run(4'(c), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    // Reset in the middle of a LOAD memory wait
    issue(4'h8, 4'h0, 1'b0);
    k = 0; g = 0;
    while (k < 3 && g < 20) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) k++;
      g++;
    end
    check("abort_reached_mem", k, 3);
    reset = 1'b0;
    model_ret = '0;
    #1;
    check_all_zero("abort_reset_outputs");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("fetch_resumed", 32'(bus.instr_req), 32'd1);
    check("abort_retired", 32'(retired), 32'd0);
    run(4'h1, 4'h0, 1'b0, 0);

    // Illegal opcode
    run(4'($urandom_range(12, 14)), 4'h0, 1'b0, 0);
    idle(5);
    do_reset();

    // HALT after some retired work
    run(4'h2, 4'h1, 1'b0, 0);
    run(4'hB, 4'h0, 1'b0, 0);
    run(4'hF, 4'h0, 1'b0, 0);
    idle(5);
    do_reset();

    // STORE with no ack reaches the memory timeout
    run(4'h9, 4'h1, 1'b0, 255);
    idle(6);
    do_reset();
    run(4'h0, 4'h0, 1'b0, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/micro_x86_seq_ctrl.md
Name: micro_x86_seq_ctrl

Overview:
Multi-cycle control sequencer for the micro-x86-64 core datapath (reg_file, decoder_hardwired, alu, memory_simple, PC register). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives instruction-fetch and data-memory handshakes. It generates every datapath control strobe: register write, memory write, b-operand select, PC update and branch select. It also counts retired instructions and reports halt, trap and fault status.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before trap (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  fetch stage presents valid instr
instr_req  output  1  request next instruction; instr accepted when instr_req & instr_valid
ir_load  output  1  latch instr into decoder input register (one cycle, on accept)
opcode  input  4  from decoder_hardwired
mode  input  4  from decoder; mode[0]=1 selects immediate as ALU b operand
zero_flag  input  1  from alu, sampled in EXEC
mem_ack  input  1  data memory completion, single-cycle pulse
b_sel_imm  output  1  ALU b = imm when 1, rdata2 when 0
rf_we  output  1  register file write enable
mem_req  output  1  data memory request
mem_we  output  1  data memory write (valid with mem_req)
pc_en  output  1  PC update strobe
pc_sel_br  output  1  with pc_en: PC <= branch target, else PC+4
halted  output  1  sticky HALT indicator
trap  output  1  sticky trap indicator
trap_code  output  2  01 illegal opcode, 10 memory timeout, 00 none
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, async): state=FETCH; all outputs 0; retired=0; timeout counter=0. Reset asserted mid-instruction aborts it with no partial rf_we/mem_we/pc_en.
- Opcode map: 0x0-0x7 ALU (write rd); 0x8 LOAD; 0x9 STORE; 0xA JZ; 0xB JMP; 0xF HALT; 0xC-0xE illegal.
- FETCH: instr_req=1. On instr_valid, pulse ir_load and go to DECODE; otherwise stay.
- DECODE: one cycle. Illegal opcode -> TRAP (code 01). HALT -> HALTED. All others -> EXEC.
- EXEC: b_sel_imm=mode[0] for ALU/LOAD/STORE (address = rdata1+imm, b_sel_imm forced 1 for LOAD/STORE).
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - JMP: pc_en=1, pc_sel_br=1, go to FETCH.
  - JZ: pc_en=1, pc_sel_br=zero_flag, go to FETCH.
- MEM: mem_req=1 and mem_we=(opcode==0x9) held until mem_ack.
  - mem_ack & STORE: pc_en=1 the same cycle, then FETCH.
  - mem_ack & LOAD: go to WB.
  - Timeout counter increments each MEM cycle without ack. Reaching MEM_TIMEOUT -> TRAP (code 10), mem_req drops.
- WB: rf_we=1 for exactly one cycle; pc_en=1 the same cycle; then FETCH.
- Retire: retired += 1 in the cycle pc_en=1 (exactly once per instruction). Wraps modulo 2^CNT_W.
- HALTED / TRAP: terminal until reset; halted resp. trap=1; instr_req, mem_req, rf_we, pc_en all 0. HALT is not counted as retired.
- Latency from instr accept: ALU 3 cycles (DECODE,EXEC,WB); JMP/JZ 2; STORE 3 + memory wait; LOAD 4 + memory wait.
- mem_ack outside MEM is ignored. instr_valid outside FETCH is ignored.
- rf_we and mem_we are never high together. pc_en is never high outside WB/EXEC-branch/MEM-store-ack.

Test Plan:
- Reset then instr_valid=1 with opcode 0x3, mode=1 -> ir_load 1 cycle after accept; b_sel_imm=1 in EXEC; rf_we and pc_en high together in WB (3rd cycle); retired=1.
- LOAD with mem_ack after 2 wait cycles -> mem_req high 3 cycles, mem_we=0; rf_we in next cycle; retired=1.
- STORE with no mem_ack, MEM_TIMEOUT=15 -> mem_req high 15 cycles, then trap=1, trap_code=10; instr_req stays 0 thereafter.
- JZ with zero_flag=1, then JZ with zero_flag=0 -> pc_en & pc_sel_br=1, then pc_en=1 with pc_sel_br=0; retired=2.
- opcode 0xD -> trap=1, trap_code=01, no rf_we/pc_en. opcode 0xF -> halted=1, retired unchanged.
- Assert reset for 1 cycle during LOAD MEM wait -> all outputs 0 immediately; FETCH resumes; retired=0; later mem_ack pulse ignored.
